// File: rtl/video_timing_pattern.sv
// Parametrised video timing generator with built-in test-pattern source (bars, gradient, checker, solid).
// Optional VIDEO_BORDER_EN: forces a one-pixel white border around the active area.
module video_timing_pattern #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int H_SYNC_POS = 0,
   parameter int V_SYNC_POS = 0,
   parameter int BPC        = 8,
   parameter int CHECK_LOG2 = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   input  logic [1:0]       i_mode,
   input  logic [3*BPC-1:0] i_solid,
   output logic             o_enable,
   output logic             o_newline,
   output logic             o_newframe,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic [15:0]      o_x,
   output logic [15:0]      o_y,
   output logic [3*BPC-1:0] o_pixel,
   output logic [15:0]      o_frame
);

   localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
   localparam logic [15:0] H_SS   = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] H_SE   = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] H_LAST = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
   localparam logic [15:0] V_SS   = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] V_SE   = 16'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [15:0] V_LAST = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic        HS_ON  = (H_SYNC_POS != 0);
   localparam logic        VS_ON  = (V_SYNC_POS != 0);
   localparam logic [18:0] H_DIV  = 19'(H_ACTIVE);
   localparam logic [BPC-1:0]   FULL  = '1;
   localparam logic [3*BPC-1:0] WHITE = {3{FULL}};

   logic [15:0]      h_cnt, v_cnt;
   logic [1:0]       mode_q, cur_mode;
   logic             frame_start, active, hs_act, vs_act;
   logic [2:0]       bar;
   logic [3*BPC-1:0] pattern, pixel_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!i_run) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
      end else begin
         h_cnt <= h_cnt + 16'd1;
      end
   end

   // The pixel at (0,0) already belongs to the new frame, so it uses i_mode directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              mode_q <= '0;
      else if (!i_run)      mode_q <= '0;
      else if (frame_start) mode_q <= i_mode;
   end

   always_comb begin
      frame_start = (h_cnt == 16'd0) && (v_cnt == 16'd0);
      cur_mode    = frame_start ? i_mode : mode_q;
      active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs_act      = (h_cnt >= H_SS) && (h_cnt < H_SE);
      vs_act      = (v_cnt >= V_SS) && (v_cnt < V_SE);
      bar         = 3'({h_cnt, 3'b000} / H_DIV);
      pattern     = '0;
      case (cur_mode)
         // bar index bits map directly to absent colours: bit2=no G, bit1=no R, bit0=no B
         2'd0:    pattern = {{BPC{~bar[1]}}, {BPC{~bar[2]}}, {BPC{~bar[0]}}};
         2'd1:    pattern = {3{h_cnt[BPC-1:0]}};
         2'd2:    pattern = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? WHITE : '0;
         default: pattern = i_solid;
      endcase
`ifdef VIDEO_BORDER_EN
      if ((h_cnt == 16'd0) || (h_cnt == H_ACT - 16'd1) ||
          (v_cnt == 16'd0) || (v_cnt == V_ACT - 16'd1))
         pattern = WHITE;
`endif
      pixel_next = active ? pattern : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || !i_run) begin
         o_enable   <= 1'b0;
         o_newline  <= 1'b0;
         o_newframe <= 1'b0;
         o_hsync    <= ~HS_ON;
         o_vsync    <= ~VS_ON;
         o_x        <= '0;
         o_y        <= '0;
         o_pixel    <= '0;
      end else begin
         o_enable   <= active;
         o_newline  <= (h_cnt == 16'd0);
         o_newframe <= frame_start;
         o_hsync    <= hs_act ? HS_ON : ~HS_ON;
         o_vsync    <= vs_act ? VS_ON : ~VS_ON;
         o_x        <= active ? h_cnt : 16'd0;
         o_y        <= active ? v_cnt : 16'd0;
         o_pixel    <= pixel_next;
      end
   end

   // Frame count survives i_run=0; only rst clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     o_frame <= '0;
      else if (i_run && frame_start) o_frame <= o_frame + 16'd1;
   end

endmodule

// File: tb/tb_video_timing_pattern.sv
// Randomised bench for video_timing_pattern in a 16x8 miniature mode against a positional model.
// Define VIDEO_BORDER_EN for both bench and design to exercise the border option.
module tb_video_timing_pattern;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_run;
   logic [1:0]  i_mode;
   logic [23:0] i_solid;
   logic        o_enable, o_newline, o_newframe, o_hsync, o_vsync;
   logic [15:0] o_x, o_y, o_frame;
   logic [23:0] o_pixel;

   video_timing_pattern #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .H_SYNC_POS(0), .V_SYNC_POS(0), .BPC(8), .CHECK_LOG2(1)
   ) dut (
      .clk(clk), .rst(rst), .i_run(i_run), .i_mode(i_mode), .i_solid(i_solid),
      .o_enable(o_enable), .o_newline(o_newline), .o_newframe(o_newframe),
      .o_hsync(o_hsync), .o_vsync(o_vsync), .o_x(o_x), .o_y(o_y),
      .o_pixel(o_pixel), .o_frame(o_frame)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;
   logic frame_preset = 1'b0;

   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] pat(input logic [1:0] m, input int h, input int v,
                                       input logic [23:0] s);
      logic [23:0] p;
      case (m)
         2'd0:    p = bars[(h * 8) / 8];
         2'd1:    p = {3{8'(h % 256)}};
         2'd2:    p = ((((h / 2) + (v / 2)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
         default: p = s;
      endcase
`ifdef VIDEO_BORDER_EN
      if (h == 0 || h == 7 || v == 0 || v == 3) p = 24'hFFFFFF;
`endif
      return p;
   endfunction

   // Model: pos = pixel slots since the run (re)started; outputs for slot pos appear one edge later.
   int          pos;
   logic        e_en, e_nl, e_nf, e_hs, e_vs;
   logic [15:0] e_x, e_y, e_frame;
   logic [23:0] e_pix;
   logic [1:0]  e_mode;

   always @(posedge clk) begin
      int h, v;
      if (rst) begin
         pos = 0; e_frame = 16'd0; e_mode = 2'd0;
         e_en = 0; e_nl = 0; e_nf = 0; e_hs = 1; e_vs = 1; e_x = 0; e_y = 0; e_pix = 0;
      end else begin
         if (frame_preset) e_frame = 16'hFFFF;
         if (!i_run) begin
            pos = 0; e_mode = 2'd0;
            e_en = 0; e_nl = 0; e_nf = 0; e_hs = 1; e_vs = 1; e_x = 0; e_y = 0; e_pix = 0;
         end else begin
            h = pos % 16;
            v = (pos / 16) % 8;
            pos = (pos + 1) % 128;
            if (h == 0 && v == 0) begin
               e_mode  = i_mode;
               e_frame = e_frame + 16'd1;
            end
            e_en  = (h < 8) && (v < 4);
            e_nl  = (h == 0);
            e_nf  = (h == 0) && (v == 0);
            e_hs  = !(h == 10 || h == 11);
            e_vs  = (v != 5);
            e_x   = 16'(h);
            e_y   = 16'(v);
            e_pix = e_en ? pat(e_mode, h, v, i_solid) : 24'h0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("enable",   32'(o_enable),   32'(e_en));
         check("newline",  32'(o_newline),  32'(e_nl));
         check("newframe", 32'(o_newframe), 32'(e_nf));
         check("hsync",    32'(o_hsync),    32'(e_hs));
         check("vsync",    32'(o_vsync),    32'(e_vs));
         check("pixel",    32'(o_pixel),    32'(e_pix));
         check("frame",    32'(o_frame),    32'(e_frame));
         if (e_en) begin
            check("x", 32'(o_x), 32'(e_x));
            check("y", 32'(o_y), 32'(e_y));
         end
      end
   end

   initial begin
      int idx, first_hs, first_vs, hs_low, vs_low, cnt;
      logic [15:0] f;
      rst = 1'b1; i_run = 1'b0; i_mode = 2'd0; i_solid = 24'h0;
      @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_hsync", 32'(o_hsync),  1);
      check("rst_vsync", 32'(o_vsync),  1);
      check("rst_en",    32'(o_enable), 0);
      check("rst_frame", 32'(o_frame),  0);
      check("rst_pixel", 32'(o_pixel),  0);

      rst = 1'b0; i_run = 1'b1;
      @(negedge clk);
      check("first_newframe", 32'(o_newframe), 1);
      check("first_newline",  32'(o_newline),  1);
      check("first_enable",   32'(o_enable),   1);
      check("first_x",        32'(o_x),        0);
      check("first_frame",    32'(o_frame),    1);
      check("bar0", 32'(o_pixel), 32'h00FFFFFF);
      for (int x = 1; x < 8; x++) begin
         @(negedge clk);
         check("bar_line0", 32'(o_pixel), 32'(bars[x]));
      end
      @(negedge clk);
      check("blank_pixel", 32'(o_pixel), 0);
      idx = 8; first_hs = -1; first_vs = -1; hs_low = 0; vs_low = 0;
      do begin
         @(negedge clk);
         idx++;
         if (!o_hsync) begin hs_low++; if (first_hs < 0) first_hs = idx; end
         if (!o_vsync) begin vs_low++; if (first_vs < 0) first_vs = idx; end
      end while (!o_newframe && idx < 400);
      check("frame_period", 32'(idx), 128);
      check("hs_first", 32'(first_hs), 10);
      check("hs_count", 32'(hs_low), 16);
      check("vs_first", 32'(first_vs), 80);
      check("vs_count", 32'(vs_low), 16);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         i_solid = 24'($urandom);
         if ($urandom_range(0, 63) == 0) i_mode = 2'($urandom_range(0, 3));
         if (i_run && $urandom_range(0, 299) == 0) i_run = 1'b0;
         else if (!i_run && $urandom_range(0, 3) == 0) i_run = 1'b1;
      end

      // mid-frame mode change 0 -> 2
      @(negedge clk); i_run = 1'b0; i_mode = 2'd0;
      @(negedge clk); i_run = 1'b1;
      repeat (40) @(negedge clk);
      i_mode = 2'd2;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!o_newframe && cnt < 300);
      check("mode_newframe", 32'(o_newframe), 1);
      check("chk_x0_y0", 32'(o_pixel), 32'h000000);
      repeat (2) @(negedge clk);
      check("chk_x2_y0", 32'(o_pixel), 32'hFFFFFF);
      repeat (30) @(negedge clk);
      check("chk_x0_y2", 32'(o_pixel), 32'hFFFFFF);
      repeat (2) @(negedge clk);
      check("chk_x2_y2", 32'(o_pixel), 32'h000000);

      // drop i_run with the counters at h=5, v=2
      @(negedge clk); i_run = 1'b0;
      @(negedge clk); i_run = 1'b1;
      repeat (37) @(negedge clk);
      i_run = 1'b0;
      f = e_frame;
      @(negedge clk);
      check("drop_en",       32'(o_enable),   0);
      check("drop_newline",  32'(o_newline),  0);
      check("drop_newframe", 32'(o_newframe), 0);
      check("drop_hsync",    32'(o_hsync),    1);
      check("drop_vsync",    32'(o_vsync),    1);
      check("drop_pixel",    32'(o_pixel),    0);
      check("drop_frame",    32'(o_frame),    32'(f));
      i_run = 1'b1;
      @(negedge clk);
      check("restart_newframe", 32'(o_newframe), 1);
      check("restart_frame",    32'(o_frame),    32'(f + 16'd1));

      // frame counter wrap
      @(negedge clk); i_run = 1'b0;
      @(negedge clk);
      #1;
      force dut.o_frame = 16'hFFFF;
      frame_preset = 1'b1;
      @(negedge clk);
      frame_preset = 1'b0;
      release dut.o_frame;
      check("preset_frame", 32'(o_frame), 32'h0000FFFF);
      i_run = 1'b1;
      @(negedge clk);
      check("wrap_newframe", 32'(o_newframe), 1);
      check("wrap_frame",    32'(o_frame),    0);

`ifdef VIDEO_BORDER_EN
      @(negedge clk); i_run = 1'b0; i_mode = 2'd3; i_solid = 24'h123456;
      @(negedge clk); i_run = 1'b1;
      @(negedge clk);
      check("border_x0", 32'(o_pixel), 32'hFFFFFF);
      repeat (19) @(negedge clk);
      check("border_x3_y1", 32'(o_pixel), 32'h123456);
`endif

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
